// File: rtl/ldgm_pkg.sv
// rtl/ldgm_pkg.sv - shared LDGM constants and accumulator state type
package ldgm_pkg;

    localparam int VEC_LEN   = 9800;
    localparam int BLK_LEN   = 140;
    localparam int SUB_LEN   = 10;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = (VEC_LEN + WORD_W - 1) / WORD_W;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        READOUT
    } acc_state_t;

endpackage

// File: rtl/sig_accumulator_if.sv
// rtl/sig_accumulator_if.sv - vector input and word readout signals of sig_accumulator
interface sig_accumulator_if;
    import ldgm_pkg::*;

    logic                  start;
    logic                  vec_valid;
    logic [0:VEC_LEN-1]    vec_in;
    logic                  busy;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_W-1:0]     out_data;
    logic                  done;
    logic                  err;

    modport master (
        output start, vec_valid, vec_in, out_ready,
        input  busy, out_valid, out_data, done, err
    );

    modport slave (
        input  start, vec_valid, vec_in, out_ready,
        output busy, out_valid, out_data, done, err
    );

endinterface

// File: rtl/sig_accumulator.sv
// rtl/sig_accumulator.sv - XOR-accumulates NUM_VEC one-hot vectors, then streams the result MSB-first
module sig_accumulator
    import ldgm_pkg::*;
#(
    parameter int NUM_VEC = 10
) (
    input  logic              clk,
    input  logic              rst_b,
    sig_accumulator_if.slave  bus
);

    localparam int CNT_W = $clog2(NUM_VEC + 1);
    localparam int PTR_W = $clog2(NUM_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_VEC - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_WORDS - 1);

    acc_state_t          state_q, state_d;
    logic [0:VEC_LEN-1]  acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        err_d   = err_q;

        // start has priority over everything, including a coincident vector
        if (bus.start) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ptr_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.vec_valid) err_d = 1'b1;
                end
                ACCUM: begin
                    if (bus.vec_valid) begin
                        acc_d = acc_q ^ bus.vec_in;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_d = READOUT;
                            ptr_d   = '0;
                        end
                    end
                end
                READOUT: begin
                    if (bus.vec_valid) err_d = 1'b1;
                    // acc doubles as the shift register: the next word moves to acc[0:WORD_W-1]
                    if (bus.out_ready) begin
                        acc_d = acc_q << WORD_W;
                        ptr_d = ptr_q + PTR_W'(1);
                        if (ptr_q == PTR_LAST) begin
                            state_d = IDLE;
                            ptr_d   = '0;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d  = (state_d != IDLE);
        valid_d = (state_d == READOUT);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = acc_q[0:WORD_W-1];
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_sig_accumulator.sv
// tb/tb_sig_accumulator.sv - directed self-checking bench for sig_accumulator
module tb_sig_accumulator;
    import ldgm_pkg::*;

    logic               clk = 1'b0;
    logic               rst_b = 1'b0;
    int                 sel = 0;
    logic               start = 1'b0;
    logic               vec_valid = 1'b0;
    logic [0:VEC_LEN-1] vec_in = '0;
    logic               out_ready = 1'b0;
    logic               busy, out_valid, done, err;
    logic [WORD_W-1:0]  out_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WORD_W-1:0] words [NUM_WORDS];
    int n_hs, n_done, hold_bad, early_done, nonzero;
    logic done_after, busy_after;

    always #5 clk = ~clk;

    sig_accumulator_if bus2 ();
    sig_accumulator_if bus1 ();
    sig_accumulator_if bus10 ();

    assign bus2.start      = start && (sel == 0);
    assign bus2.vec_valid  = vec_valid && (sel == 0);
    assign bus2.vec_in     = vec_in;
    assign bus2.out_ready  = out_ready && (sel == 0);
    assign bus1.start      = start && (sel == 1);
    assign bus1.vec_valid  = vec_valid && (sel == 1);
    assign bus1.vec_in     = vec_in;
    assign bus1.out_ready  = out_ready && (sel == 1);
    assign bus10.start     = start && (sel == 2);
    assign bus10.vec_valid = vec_valid && (sel == 2);
    assign bus10.vec_in    = vec_in;
    assign bus10.out_ready = out_ready && (sel == 2);

    sig_accumulator #(.NUM_VEC(2))  u_dut2  (.clk(clk), .rst_b(rst_b), .bus(bus2));
    sig_accumulator #(.NUM_VEC(1))  u_dut1  (.clk(clk), .rst_b(rst_b), .bus(bus1));
    sig_accumulator #(.NUM_VEC(10)) u_dut10 (.clk(clk), .rst_b(rst_b), .bus(bus10));

    always_comb begin
        busy = bus2.busy; out_valid = bus2.out_valid; out_data = bus2.out_data;
        done = bus2.done; err = bus2.err;
        if (sel == 1) begin
            busy = bus1.busy; out_valid = bus1.out_valid; out_data = bus1.out_data;
            done = bus1.done; err = bus1.err;
        end else if (sel == 2) begin
            busy = bus10.busy; out_valid = bus10.out_valid; out_data = bus10.out_data;
            done = bus10.done; err = bus10.err;
        end
    end

    function automatic logic [0:VEC_LEN-1] onehot(input int idx);
        logic [0:VEC_LEN-1] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_vec(input int idx);
        vec_in = onehot(idx);
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
    endtask

    // Drains one readout; bp selects the ready pattern 1,0,0,1,0,0,...
    task automatic collect(input bit bp);
        int guard;
        int k;
        logic [WORD_W-1:0] held;
        bit holding;
        guard = 0; k = 0; held = '0; holding = 1'b0;
        n_hs = 0; n_done = 0; hold_bad = 0; early_done = 0;
        while (n_hs < NUM_WORDS && guard < 3000) begin
            if (done) early_done++;
            if (holding && out_data !== held) hold_bad++;
            out_ready = bp ? (k % 3 == 0) : 1'b1;
            k++;
            if (out_valid && out_ready) begin
                words[n_hs] = out_data;
                n_hs++;
            end
            holding = out_valid && !out_ready;
            held = out_data;
            tick();
            guard++;
        end
        out_ready = 1'b0;
        done_after = done;
        busy_after = busy;
        for (int i = 0; i < 5; i++) begin
            if (done) n_done++;
            tick();
        end
        nonzero = 0;
        for (int i = 0; i < n_hs; i++) if (words[i] != '0) nonzero++;
    endtask

    task automatic test_reset();
        sel = 0;
        rst_b = 1'b0;
        tick(); tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        #3 rst_b = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        sel = 0;
        pulse_start();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_after_start: got %b expected 1", busy); end
        send_vec(0);
        send_vec(VEC_LEN - 1);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
        collect(1'b0);
        n_tests++; if (n_hs !== NUM_WORDS) begin n_fail++; $display("FAIL basic_handshakes: got %0d expected %0d", n_hs, NUM_WORDS); end
        n_tests++; if (words[0] !== 32'h8000_0000) begin n_fail++; $display("FAIL basic_word0: got %h expected 80000000", words[0]); end
        n_tests++; if (words[306] !== 32'h0100_0000) begin n_fail++; $display("FAIL basic_word306: got %h expected 01000000", words[306]); end
        n_tests++; if (nonzero !== 2) begin n_fail++; $display("FAIL basic_nonzero_words: got %0d expected 2", nonzero); end
        n_tests++; if (early_done !== 0) begin n_fail++; $display("FAIL basic_early_done: got %0d expected 0", early_done); end
        n_tests++; if (done_after !== 1'b1 || busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_done_timing: got done=%b busy=%b expected done=1 busy=0", done_after, busy_after); end
        n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", n_done); end
    endtask

    task automatic test_cancel();
        sel = 0;
        pulse_start();
        send_vec(1430);
        send_vec(1430);
        collect(1'b0);
        n_tests++; if (n_hs !== NUM_WORDS) begin n_fail++; $display("FAIL cancel_handshakes: got %0d expected %0d", n_hs, NUM_WORDS); end
        n_tests++; if (nonzero !== 0) begin n_fail++; $display("FAIL cancel_nonzero_words: got %0d expected 0", nonzero); end
        n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL cancel_done_count: got %0d expected 1", n_done); end
    endtask

    task automatic test_backpressure();
        sel = 1;
        pulse_start();
        send_vec(33);
        collect(1'b1);
        n_tests++; if (n_hs !== NUM_WORDS) begin n_fail++; $display("FAIL bp_handshakes: got %0d expected %0d", n_hs, NUM_WORDS); end
        n_tests++; if (words[0] !== 32'h0) begin n_fail++; $display("FAIL bp_word0: got %h expected 00000000", words[0]); end
        n_tests++; if (words[1] !== 32'h4000_0000) begin n_fail++; $display("FAIL bp_word1: got %h expected 40000000", words[1]); end
        n_tests++; if (nonzero !== 1) begin n_fail++; $display("FAIL bp_nonzero_words: got %0d expected 1", nonzero); end
        n_tests++; if (hold_bad !== 0) begin n_fail++; $display("FAIL bp_hold_stable: got %0d changes expected 0", hold_bad); end
        n_tests++; if (early_done !== 0 || done_after !== 1'b1) begin n_fail++; $display("FAIL bp_done_timing: got early=%0d after=%b expected early=0 after=1", early_done, done_after); end
        n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL bp_done_count: got %0d expected 1", n_done); end
    endtask

    task automatic test_abort();
        sel = 2;
        pulse_start();
        for (int i = 0; i < 5; i++) send_vec(5);
        pulse_start();
        n_tests++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_restart: got busy=%b out_valid=%b expected busy=1 out_valid=0", busy, out_valid); end
        for (int i = 0; i < 10; i++) send_vec(5);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL abort_out_valid: got %b expected 1", out_valid); end
        collect(1'b0);
        n_tests++; if (words[0] !== 32'h0 || nonzero !== 0) begin n_fail++; $display("FAIL abort_result: got word0=%h nonzero=%0d expected 0 and 0", words[0], nonzero); end
        n_tests++; if (n_done !== 1 || early_done !== 0) begin n_fail++; $display("FAIL abort_done_count: got %0d early=%0d expected 1 early=0", n_done, early_done); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b expected 0", err); end
    endtask

    task automatic test_error();
        sel = 0;
        send_vec(0);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_idle_vec: got %b expected 1", err); end
        n_tests++; if (out_data !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL err_idle_acc: got data=%h busy=%b expected 00000000 and 0", out_data, busy); end
        start = 1'b1;
        send_vec(0);
        start = 1'b0;
        n_tests++; if (err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL err_start_clears: got err=%b busy=%b expected 0 and 1", err, busy); end
        send_vec(0);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL err_vec_not_counted: got out_valid=%b expected 0", out_valid); end
        send_vec(VEC_LEN - 1);
        n_tests++; if (out_valid !== 1'b1 || out_data !== 32'h8000_0000) begin n_fail++; $display("FAIL err_vec_discarded: got valid=%b data=%h expected 1 80000000", out_valid, out_data); end
        collect(1'b0);
        n_tests++; if (n_done !== 1 || words[306] !== 32'h0100_0000) begin n_fail++; $display("FAIL err_readout: got done=%0d word306=%h expected 1 01000000", n_done, words[306]); end
    endtask

    task automatic test_reset_readout();
        sel = 0;
        pulse_start();
        send_vec(0);
        send_vec(VEC_LEN - 1);
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        #2 rst_b = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outputs: got valid=%b busy=%b done=%b expected 0 0 0", out_valid, busy, done); end
        n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h expected 00000000", out_data); end
        out_ready = 1'b0;
        tick();
        #3 rst_b = 1'b1;
        tick();
        pulse_start();
        send_vec(40);
        send_vec(VEC_LEN - 1);
        collect(1'b0);
        n_tests++; if (words[1] !== 32'h0080_0000) begin n_fail++; $display("FAIL rst_rerun_word1: got %h expected 00800000", words[1]); end
        n_tests++; if (words[306] !== 32'h0100_0000 || nonzero !== 2) begin n_fail++; $display("FAIL rst_rerun_word306: got %h nonzero=%0d expected 01000000 2", words[306], nonzero); end
        n_tests++; if (n_done !== 1 || n_hs !== NUM_WORDS) begin n_fail++; $display("FAIL rst_rerun_done: got done=%0d hs=%0d expected 1 %0d", n_done, n_hs, NUM_WORDS); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cancel();
        test_backpressure();
        test_abort();
        test_error();
        test_reset_readout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
